ysyx_22041461_sram_2p: RTL

Parametrised simple-dual-port SRAM model (one write port, one read port) for NPC cache data/tag arrays. Keeps the active-low macro-style strobes and per-bit write mask of the single-port SRAM. Adds:
- a post-reset zero-fill sequencer with BUSY;
- configurable read latency with a valid flag;
- defined same-address read/write collision behaviour.

---
 rtl/ysyx_22041461_sram_pkg.sv | 24 ++
 rtl/ysyx_22041461_sram_array.sv | 50 +++++
 rtl/ysyx_22041461_sram_2p.sv | 121 ++++++++++++
 3 files changed

// File: rtl/ysyx_22041461_sram_pkg.sv
// Shared types and helpers for the simple-dual-port SRAM model.
// Masked merge is written at a fixed wide width; callers cast to their own BITS.
package ysyx_22041461_sram_pkg;

   typedef enum logic {
      S_INIT,
      S_READY
   } state_t;

   localparam int RD_LAT_1 = 1;
   localparam int RD_LAT_2 = 2;

   localparam int MERGE_W = 1024;

   // Active-low mask: a 0 in mask_n takes the new data bit, a 1 keeps the old bit.
   function automatic logic [MERGE_W-1:0] sram_merge(
      input logic [MERGE_W-1:0] data,
      input logic [MERGE_W-1:0] old,
      input logic [MERGE_W-1:0] mask_n
   );
      return (data & ~mask_n) | (old & mask_n);
   endfunction

endpackage

// File: rtl/ysyx_22041461_sram_array.sv
// Bare storage: one masked write port, one registered read port, same-address collision mux.
// Read data appears one edge after re; no backpressure, every enabled access completes.
module ysyx_22041461_sram_array
   import ysyx_22041461_sram_pkg::*;
#(
   parameter int BITS       = 128,
   parameter int WORD_DEPTH = 64,
   parameter int ADD_WIDTH  = $clog2(WORD_DEPTH),
   parameter int WR_FWD     = 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 we,
   input  logic [ADD_WIDTH-1:0] wa,
   input  logic [BITS-1:0]      wd,
   input  logic [BITS-1:0]      wmask_n,
   input  logic                 re,
   input  logic [ADD_WIDTH-1:0] ra,
   output logic [BITS-1:0]      rq,
   output logic                 rvalid
);

   logic [BITS-1:0] mem [WORD_DEPTH];
   logic [BITS-1:0] merged;
   logic            fwd;

   assign merged = BITS'(sram_merge(MERGE_W'(wd), MERGE_W'(mem[wa]), MERGE_W'(wmask_n)));

   // Read-first falls out of the non-blocking update; write-first needs the bypass.
   assign fwd = (WR_FWD != 0) && we && (wa == ra);

   always_ff @(posedge clk) begin
      if (we) begin
         mem[wa] <= merged;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rq     <= '0;
         rvalid <= 1'b0;
      end else begin
         rvalid <= re;
         if (re) begin
            rq <= fwd ? merged : mem[ra];
         end
      end
   end

endmodule

// File: rtl/ysyx_22041461_sram_2p.sv
// Simple-dual-port SRAM with post-reset zero-fill (BUSY), read latency 1 or 2 with RVALID.
// No backpressure: accesses while BUSY or in reset are dropped, reads return after RD_LATENCY edges.
module ysyx_22041461_sram_2p
   import ysyx_22041461_sram_pkg::*;
#(
   parameter int BITS       = 128,
   parameter int WORD_DEPTH = 64,
   parameter int ADD_WIDTH  = $clog2(WORD_DEPTH),
   parameter int RD_LATENCY = 1,
   parameter int INIT_ZERO  = 1,
   parameter int WR_FWD     = 1
) (
   input  logic                 CLK,
   input  logic                 RST,
   input  logic                 WCEN,
   input  logic [BITS-1:0]      WBWEN,
   input  logic [ADD_WIDTH-1:0] WA,
   input  logic [BITS-1:0]      WD,
   input  logic                 RCEN,
   input  logic [ADD_WIDTH-1:0] RA,
   output logic [BITS-1:0]      RQ,
   output logic                 RVALID,
   output logic                 BUSY
);

   if (RD_LATENCY != RD_LAT_1 && RD_LATENCY != RD_LAT_2) begin : g_bad_lat
      $error("ysyx_22041461_sram_2p: RD_LATENCY must be 1 or 2");
   end
   if (WORD_DEPTH < 2 || (WORD_DEPTH & (WORD_DEPTH - 1)) != 0) begin : g_bad_depth
      $error("ysyx_22041461_sram_2p: WORD_DEPTH must be a power of two >= 2");
   end
   if (BITS > MERGE_W) begin : g_bad_bits
      $error("ysyx_22041461_sram_2p: BITS exceeds merge helper width");
   end

   localparam logic [ADD_WIDTH-1:0] LAST_ADDR = ADD_WIDTH'(WORD_DEPTH - 1);

   state_t               state, state_nxt;
   logic [ADD_WIDTH-1:0] cnt, cnt_nxt;
   logic                 fill;
   logic                 ready;
   logic                 arr_we;
   logic                 arr_re;
   logic [ADD_WIDTH-1:0] arr_wa;
   logic [BITS-1:0]      arr_wd;
   logic [BITS-1:0]      arr_mask_n;
   logic [BITS-1:0]      arr_rq;
   logic                 arr_rvalid;

   always_ff @(posedge CLK) begin
      if (RST) begin
         state <= (INIT_ZERO != 0) ? S_INIT : S_READY;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      fill      = 1'b0;
      case (state)
         S_INIT: begin
            fill    = 1'b1;
            cnt_nxt = cnt + ADD_WIDTH'(1);
            if (cnt == LAST_ADDR) begin
               state_nxt = S_READY;
            end
         end
         default: ;
      endcase
   end

   assign BUSY  = (state == S_INIT);
   assign ready = (state == S_READY) && !RST;

   // The fill sequencer borrows the write port; user strobes are ignored until it hands back.
   assign arr_we     = (fill && !RST) || (ready && !WCEN);
   assign arr_wa     = fill ? cnt : WA;
   assign arr_wd     = fill ? '0 : WD;
   assign arr_mask_n = fill ? '0 : WBWEN;
   assign arr_re     = ready && !RCEN;

   ysyx_22041461_sram_array #(
      .BITS       (BITS),
      .WORD_DEPTH (WORD_DEPTH),
      .ADD_WIDTH  (ADD_WIDTH),
      .WR_FWD     (WR_FWD)
   ) u_array (
      .clk     (CLK),
      .rst     (RST),
      .we      (arr_we),
      .wa      (arr_wa),
      .wd      (arr_wd),
      .wmask_n (arr_mask_n),
      .re      (arr_re),
      .ra      (RA),
      .rq      (arr_rq),
      .rvalid  (arr_rvalid)
   );

   if (RD_LATENCY == RD_LAT_2) begin : g_lat2
      always_ff @(posedge CLK) begin
         if (RST) begin
            RQ     <= '0;
            RVALID <= 1'b0;
         end else begin
            RVALID <= arr_rvalid;
            if (arr_rvalid) begin
               RQ <= arr_rq;
            end
         end
      end
   end else begin : g_lat1
      assign RQ     = arr_rq;
      assign RVALID = arr_rvalid;
   end

endmodule
